// File: rtl/nios_pio_out_pkg.sv
// Shared register-map constants and pulse-engine state encoding for the output PIO.
package nios_pio_out_pkg;

  localparam logic [2:0] ADDR_DATA       = 3'd0;
  localparam logic [2:0] ADDR_PULSE_LEN  = 3'd2;
  localparam logic [2:0] ADDR_PULSE_TRIG = 3'd3;
  localparam logic [2:0] ADDR_OUTSET     = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR   = 3'd5;

  typedef enum logic {
    PS_IDLE,
    PS_ACTIVE
  } pulse_state_t;

endpackage

// File: rtl/nios_pio_pulse_timer.sv
// One-shot pulse engine: holds an inversion mask for max(len,1) cycles after a trigger.
module nios_pio_pulse_timer
  import nios_pio_out_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned PULSE_W = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               trig,
  input  logic [WIDTH-1:0]   mask,
  input  logic [PULSE_W-1:0] len,
  output logic [WIDTH-1:0]   mask_q,
  output logic               busy
);

  pulse_state_t       state_q, state_d;
  logic [PULSE_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]   mask_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= PS_IDLE;
      cnt_q   <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    unique case (state_q)
      PS_IDLE: begin
        if (trig && (mask != '0)) begin
          mask_d  = mask;
          cnt_d   = (len == '0) ? PULSE_W'(1) : len;
          state_d = PS_ACTIVE;
        end
      end
      PS_ACTIVE: begin
        // Triggers are ignored here, including on the terminating edge.
        if (cnt_q == PULSE_W'(1)) begin
          mask_d  = '0;
          cnt_d   = '0;
          state_d = PS_IDLE;
        end else begin
          cnt_d = cnt_q - PULSE_W'(1);
        end
      end
      default: state_d = PS_IDLE;
    endcase
  end

  assign busy = (state_q == PS_ACTIVE);

endmodule

// File: rtl/nios_pio_out.sv
// Avalon-MM output PIO with atomic set/clear and a hardware one-shot inversion pulse.
module nios_pio_out
  import nios_pio_out_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter logic [31:0] RESET_VALUE = 32'h0,
  parameter int unsigned PULSE_W     = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  logic               wr_en;
  logic [WIDTH-1:0]   data_q;
  logic [PULSE_W-1:0] pulse_len_q;
  logic [WIDTH-1:0]   wd;
  logic [WIDTH-1:0]   mask_q;
  logic               busy;
  logic               trig;
  logic [31:0]        rd_mux;
  logic               unused_wd;

  assign wr_en     = chipselect && !write_n;
  assign wd        = writedata[WIDTH-1:0];
  assign trig      = wr_en && (address == ADDR_PULSE_TRIG);
  assign unused_wd = ^writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q      <= RESET_VALUE[WIDTH-1:0];
      pulse_len_q <= PULSE_W'(1);
    end else if (wr_en) begin
      unique case (address)
        ADDR_DATA:      data_q      <= wd;
        ADDR_PULSE_LEN: pulse_len_q <= writedata[PULSE_W-1:0];
        ADDR_OUTSET:    data_q      <= data_q | wd;
        ADDR_OUTCLEAR:  data_q      <= data_q & ~wd;
        default: ;
      endcase
    end
  end

  nios_pio_pulse_timer #(
    .WIDTH   (WIDTH),
    .PULSE_W (PULSE_W)
  ) u_pulse (
    .clk     (clk),
    .reset_n (reset_n),
    .trig    (trig),
    .mask    (wd),
    .len     (pulse_len_q),
    .mask_q  (mask_q),
    .busy    (busy)
  );

  always_comb begin
    rd_mux = '0;
    unique case (address)
      ADDR_DATA:       rd_mux[WIDTH-1:0]   = data_q;
      ADDR_PULSE_LEN:  rd_mux[PULSE_W-1:0] = pulse_len_q;
      ADDR_PULSE_TRIG: rd_mux[0]           = busy;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= rd_mux;
  end

  assign out_port = data_q ^ mask_q;

endmodule
